// File: rtl/ics_uart_tx.sv
// ICS UART transmitter: 8E1 framing (start, 8 data LSB first, even parity, stop)
// with a half-duplex drive enable and a one-cycle completion pulse.
// Every output is registered and is loaded from the next-state values, so each
// output changes on the same edge as the state it reflects.
module ics_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_oe,
    output logic       tx_done
);

    localparam int unsigned CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned DATA_W  = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_n;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_n;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   data_n;
    logic                bit_end;
    logic                tx_n;
    logic                tx_oe_n;
    logic                tx_ready_n;
    logic                tx_done_n;

    // State, bit-period counter, bit index and latched byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            data_q <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            data_q <= data_n;
        end
    end

    // Next-state logic: sequence through the frame one bit period at a time.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        data_n  = data_q;
        bit_end = (cnt == CNT_LAST);

        case (state)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    state_n = START;
                    cnt_n   = '0;
                    idx_n   = '0;
                    data_n  = tx_data;
                end
            end
            START: begin
                cnt_n = bit_end ? '0 : cnt + CNT_W'(1);
                if (bit_end) begin
                    state_n = DATA;
                    idx_n   = '0;
                end
            end
            DATA: begin
                cnt_n = bit_end ? '0 : cnt + CNT_W'(1);
                if (bit_end) begin
                    if (idx == IDX_LAST) begin
                        state_n = PARITY;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                cnt_n = bit_end ? '0 : cnt + CNT_W'(1);
                if (bit_end) begin
                    state_n = STOP;
                end
            end
            STOP: begin
                cnt_n = bit_end ? '0 : cnt + CNT_W'(1);
                if (bit_end) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                idx_n   = '0;
            end
        endcase
    end

    // Output values for the cycle that follows, derived from the next state.
    always_comb begin
        tx_n       = 1'b1;
        tx_oe_n    = (state_n != IDLE);
        tx_ready_n = (state_n == IDLE);
        tx_done_n  = (state_n == STOP) && (cnt_n == CNT_LAST);

        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = data_n[idx_n];
            PARITY:  tx_n = ^data_n;
            default: tx_n = 1'b1;
        endcase
    end

    // Registered outputs; reset leaves the line idle-high and undriven.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx       <= 1'b1;
            tx_oe    <= 1'b0;
            tx_ready <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            tx       <= tx_n;
            tx_oe    <= tx_oe_n;
            tx_ready <= tx_ready_n;
            tx_done  <= tx_done_n;
        end
    end

endmodule

// File: tb/tb_ics_uart_tx.sv
// Bench for ics_uart_tx: three instances (4, 2 and 868 clocks per bit) checked
// every cycle against a frame-position model, plus literal frame pins.
module tb_ics_uart_tx;

    logic       clk;
    logic [2:0] rst_v;
    logic [2:0] tx_valid;
    logic [7:0] tx_data [3];
    logic [2:0] tx_ready_w;
    logic [2:0] tx_w;
    logic [2:0] tx_oe_w;
    logic [2:0] tx_done_w;

    int checks = 0;
    int errors = 0;
    int timeouts = 0;
    logic pin_req = 1'b0;
    logic pins_done = 1'b0;

    // Model: position within the current frame (-1 when idle) and its 11 bits.
    int         mpos [3] = '{-1, -1, -1};
    logic [10:0] mframe [3];

    // Frame recorder built from the DUT outputs.
    int          run [3]      = '{0, 0, 0};
    int          idle_run [3] = '{0, 0, 0};
    int          rdy_run [3]  = '{0, 0, 0};
    int          cur_gap [3]  = '{0, 0, 0};
    int          cur_rdy [3]  = '{0, 0, 0};
    int          cur_done [3] = '{0, 0, 0};
    logic [10:0] cur_bits [3];
    logic [10:0] log_bits [3][12];
    int          log_len [3][12];
    int          log_done [3][12];
    int          log_gap [3][12];
    int          log_rdy [3][12];
    int          log_n [3] = '{0, 0, 0};

    logic [3:0] exp_v;
    logic [3:0] got_v;
    int         cper;

    ics_uart_tx #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk(clk), .rst(rst_v[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready_w[0]), .tx(tx_w[0]), .tx_oe(tx_oe_w[0]), .tx_done(tx_done_w[0])
    );
    ics_uart_tx #(.CLKS_PER_BIT(2)) u_dut2 (
        .clk(clk), .rst(rst_v[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready_w[1]), .tx(tx_w[1]), .tx_oe(tx_oe_w[1]), .tx_done(tx_done_w[1])
    );
    ics_uart_tx #(.CLKS_PER_BIT(868)) u_dut868 (
        .clk(clk), .rst(rst_v[2]), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready_w[2]), .tx(tx_w[2]), .tx_oe(tx_oe_w[2]), .tx_done(tx_done_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cpb(input int i);
        case (i)
            0:       return 4;
            1:       return 2;
            default: return 868;
        endcase
    endfunction

    // Model update: a frame lasts 11 bit periods starting the cycle after acceptance.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_v[i]) begin
                mpos[i] <= -1;
            end else if (mpos[i] < 0) begin
                if (tx_valid[i]) begin
                    mpos[i]   <= 0;
                    mframe[i] <= {1'b1, ^tx_data[i], tx_data[i], 1'b0};
                end
            end else if (mpos[i] + 1 >= 11 * cpb(i)) begin
                mpos[i] <= -1;
            end else begin
                mpos[i] <= mpos[i] + 1;
            end
        end
    end

    task automatic pin(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic pin_frame(input int i, input int k, input logic [10:0] bits,
                             input int len, input int done);
        pin($sformatf("dut%0d frame%0d bits", i, k), 32'(log_bits[i][k]), 32'(bits));
        pin($sformatf("dut%0d frame%0d len", i, k), log_len[i][k], len);
        pin($sformatf("dut%0d frame%0d done_at", i, k), log_done[i][k], done);
    endtask

    // Compare process: per-cycle model check, frame recording, final literal pins.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            cper = cpb(i);
            if (mpos[i] < 0) exp_v = 4'b1010;
            else exp_v = {mframe[i][mpos[i] / cper], 1'b1, 1'b0, (mpos[i] == 11 * cper - 1)};
            got_v = {tx_w[i], tx_oe_w[i], tx_ready_w[i], tx_done_w[i]};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL dut%0d outputs t=%0t got %b want %b (tx,oe,ready,done)",
                         i, $time, got_v, exp_v);
            end

            if (tx_oe_w[i] === 1'b1) begin
                if (run[i] == 0) begin
                    cur_gap[i]  = idle_run[i];
                    cur_rdy[i]  = rdy_run[i];
                    cur_bits[i] = '0;
                    cur_done[i] = 0;
                end
                if ((run[i] % cper) == 0 && (run[i] / cper) < 11)
                    cur_bits[i][run[i] / cper] = tx_w[i];
                run[i]++;
                if (tx_done_w[i] === 1'b1) cur_done[i] = run[i];
            end else begin
                if (run[i] > 0) begin
                    if (log_n[i] < 12) begin
                        log_bits[i][log_n[i]] = cur_bits[i];
                        log_len[i][log_n[i]]  = run[i];
                        log_done[i][log_n[i]] = cur_done[i];
                        log_gap[i][log_n[i]]  = cur_gap[i];
                        log_rdy[i][log_n[i]]  = cur_rdy[i];
                    end
                    log_n[i]++;
                    run[i]      = 0;
                    idle_run[i] = 0;
                    rdy_run[i]  = 0;
                end
                idle_run[i]++;
                if (tx_ready_w[i] === 1'b1) rdy_run[i]++;
            end
        end

        if (pin_req && !pins_done) begin
            pin("timeouts", timeouts, 0);
            pin("dut0 frame count", log_n[0], 9);
            pin_frame(0, 0, 11'h4AA, 44, 44);
            pin_frame(0, 1, 11'h602, 44, 44);
            pin_frame(0, 2, 11'h400, 44, 44);
            pin_frame(0, 3, 11'h5FE, 44, 44);
            pin_frame(0, 4, 11'h54A, 44, 44);
            pin_frame(0, 5, 11'h478, 44, 44);
            pin("dut0 b2b gap", log_gap[0][5], 1);
            pin("dut0 b2b ready cycles", log_rdy[0][5], 1);
            pin_frame(0, 6, 11'h586, 44, 44);
            pin_frame(0, 7, 11'h014, 18, 0);
            pin_frame(0, 8, 11'h502, 44, 44);
            pin("dut1 frame count", log_n[1], 1);
            pin_frame(1, 0, 11'h602, 22, 22);
            pin("dut2 frame count", log_n[2], 1);
            pin_frame(2, 0, 11'h4AA, 9548, 9548);
            pins_done = 1'b1;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ready(input logic lvl);
        int n;
        n = 0;
        while (tx_ready_w[0] !== lvl && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) timeouts++;
    endtask

    task automatic send_byte(input logic [7:0] d);
        tx_data[0]  = d;
        tx_valid[0] = 1'b1;
        wait_ready(1'b0);
        tx_valid[0] = 1'b0;
        wait_ready(1'b1);
    endtask

    // Directed stimulus on the 4-clock instance; 2 and 868 send one byte each.
    initial begin
        int n;
        rst_v    = 3'b111;
        tx_valid = 3'b000;
        for (int i = 0; i < 3; i++) tx_data[i] = 8'h00;
        repeat (3) tick();
        rst_v = 3'b000;
        tick();

        tx_data[0] = 8'h55;
        tx_data[1] = 8'h01;
        tx_data[2] = 8'h55;
        tx_valid   = 3'b111;
        wait_ready(1'b0);
        tx_valid = 3'b000;
        wait_ready(1'b1);

        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hFF);

        tx_data[0]  = 8'hA5;
        tx_valid[0] = 1'b1;
        wait_ready(1'b0);
        tx_data[0] = 8'h3C;
        wait_ready(1'b1);
        wait_ready(1'b0);
        tx_valid[0] = 1'b0;
        wait_ready(1'b1);

        tx_data[0]  = 8'hC3;
        tx_valid[0] = 1'b1;
        wait_ready(1'b0);
        tx_valid[0] = 1'b0;
        repeat (5) tick();
        tx_data[0]  = 8'h99;
        tx_valid[0] = 1'b1;
        tick();
        tx_valid[0] = 1'b0;
        repeat (10) tick();
        tx_data[0]  = 8'h11;
        tx_valid[0] = 1'b1;
        tick();
        tx_valid[0] = 1'b0;
        tx_data[0]  = 8'h00;
        wait_ready(1'b1);
        repeat (6) tick();

        tx_data[0]  = 8'h5A;
        tx_valid[0] = 1'b1;
        wait_ready(1'b0);
        tx_valid[0] = 1'b0;
        repeat (17) tick();
        rst_v[0] = 1'b1;
        tick();
        rst_v[0] = 1'b0;
        tick();

        send_byte(8'h81);
        repeat (4) tick();

        n = 0;
        while (tx_oe_w[2] !== 1'b0 && n < 12000) begin
            tick();
            n++;
        end
        if (n >= 12000) timeouts++;
        repeat (4) tick();

        pin_req = 1'b1;
        n = 0;
        while (!pins_done && n < 10) begin
            tick();
            n++;
        end
        if (!pins_done) $display("FAIL pin_checks got not-run want run");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
